pdf_magic_detector: RTL and testbench
=====================================

Name: pdf_magic_detector

Overview:
- Downstream consumer of the 2-bit symbol stream produced by the file-reader stage.
- Packs symbols MSB-first into bytes and scans the byte stream for the PDF magic "%PDF" (0x25 0x50 0x44 0x46).
- Reports a sticky found or fail verdict, plus the byte offset of the match.
- Feeds the file-classification / status logic of the project.

Parameters:
- MAX_BYTES, 16: search window in bytes. No match within this many bytes gives a fail verdict.
- POS_W, 5: width of the byte counter and match position. Must satisfy 2^POS_W > MAX_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous clear. Restarts packing and search; has priority over sym_valid in the same cycle.
- sym_in  in  2  input symbol.
- sym_valid  in  1  sym_in is valid this cycle.
- byte_out  out  8  last assembled byte.
- byte_valid  out  1  one-cycle pulse when byte_out updates.
- found  out  1  sticky; magic detected.
- fail  out  1  sticky; window exhausted without a match.
- match_pos  out  POS_W  byte index of the '%' of the detected magic (0-based). Valid while found=1.
- busy  out  1  high while searching (not found and not fail).

Behaviour:
- Reset (rst_n=0, async): all outputs 0 except busy=1. Symbol count=0, byte count=0, FSM=S0.
- Packing:
  - A 2-bit counter advances on each sym_valid.
  - The first symbol of a byte lands in bits [7:6], the last in [1:0].
  - On the 4th symbol, byte_out is registered and byte_valid=1 in the next cycle (latency 1 cycle from the 4th symbol).
  - The counter wraps 3->0.
  - sym_valid=0 holds all state; gaps between symbols are allowed.
- Byte counter:
  - Increments on each assembled byte while busy.
  - Saturates; never wraps.
- Matcher FSM, evaluated on each assembled byte while busy. States S0 (nothing matched), S1 ('%'), S2 ("%P"), S3 ("%PD"), FOUND, FAIL.
  - S0: 0x25 -> S1; else stay in S0.
  - S1: 0x50 -> S2; 0x25 -> S1; else S0.
  - S2: 0x44 -> S3; 0x25 -> S1; else S0.
  - S3: 0x46 -> FOUND; 0x25 -> S1; else S0.
  - On entering FOUND: found=1, busy=0, match_pos = (index of the 'F' byte) - 3.
- Fail condition: the byte counter reaches MAX_BYTES and that byte did not complete the magic -> FAIL: fail=1, busy=0.
- Simultaneous events: a completing 'F' on byte MAX_BYTES gives FOUND, not FAIL (match wins).
- found and fail are mutually exclusive.
- FOUND and FAIL are terminal:
  - Further symbols are still packed and byte_valid still pulses.
  - The verdict and match_pos hold.
- start=1:
  - Next cycle: symbol count=0, byte count=0, FSM=S0, found=0, fail=0, busy=1.
  - byte_out holds; byte_valid=0.
  - A partial byte in progress is discarded.
- Reset asserted mid-byte or mid-match: immediate return to the reset state; the partial byte is lost.

Decomposition:
- Shared package pdf_pkg holds:
  - localparams MAGIC0..MAGIC3 = 8'h25, 8'h50, 8'h44, 8'h46;
  - the FSM state encoding (3-bit: S0, S1, S2, S3, FOUND, FAIL);
  - the symbol width SYM_W = 2.
- Sub-module sym_packer (clk, rst_n, clear, sym_in, sym_valid -> byte_out, byte_valid) performs the 4-to-1 packing.
- The top level holds the byte counter and the matcher FSM.

Test Plan:
1. Reset, then start; feed symbols 0,2,1,1 / 1,1,0,0 / 1,0,1,0 / 1,0,1,2 back-to-back -> byte_out sequence 0x25, 0x50, 0x44, 0x46, each byte_valid 1 cycle after its 4th symbol; found=1 one cycle after the last byte_valid; match_pos=0; fail=0; busy=0.
2. Bytes 0x00, 0x25, 0x25, 0x50, 0x44, 0x46 with sym_valid toggling every other cycle -> found=1, match_pos=2 (re-arm on a repeated '%' and stall tolerance verified).
3. MAX_BYTES=16; 16 bytes of 0x41 -> fail=1 right after the 16th byte; found=0; further bytes still pulse byte_valid; fail holds.
4. Magic completing exactly on byte 16 (bytes 12..15 = "%PDF") -> found=1, match_pos=12, fail=0.
5. "%PD" followed by 0x47 ('G'), then "%PDF" -> no found after 0x47 (FSM back to S0); found after the second 'F'; match_pos=4.
6. rst_n pulsed low after 2 symbols of a byte, then start and the full magic -> all outputs 0 and busy=1 during reset; correct detection afterwards with match_pos=0. Also start asserted together with sym_valid -> that symbol is ignored.

Source files
------------

// File: rtl/pdf_pkg.sv
// Shared definitions for the PDF magic detector: magic bytes, symbol width and
// the matcher state encoding with its byte-step function.
package pdf_pkg;

    localparam int SYM_W  = 2;
    localparam int BYTE_W = 8;

    localparam logic [7:0] MAGIC0 = 8'h25;
    localparam logic [7:0] MAGIC1 = 8'h50;
    localparam logic [7:0] MAGIC2 = 8'h44;
    localparam logic [7:0] MAGIC3 = 8'h46;

    typedef enum logic [2:0] {
        ST_S0    = 3'd0,
        ST_S1    = 3'd1,
        ST_S2    = 3'd2,
        ST_S3    = 3'd3,
        ST_FOUND = 3'd4,
        ST_FAIL  = 3'd5
    } match_state_t;

    // Any mismatch falls back to S0, except a fresh '%' which re-arms at S1.
    function automatic match_state_t match_step(input match_state_t st,
                                                input logic [7:0]   b);
        match_state_t nxt;
        nxt = (b == MAGIC0) ? ST_S1 : ST_S0;
        case (st)
            ST_S1:    if (b == MAGIC1) nxt = ST_S2;
            ST_S2:    if (b == MAGIC2) nxt = ST_S3;
            ST_S3:    if (b == MAGIC3) nxt = ST_FOUND;
            ST_FOUND: nxt = ST_FOUND;
            ST_FAIL:  nxt = ST_FAIL;
            default:  ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sym_packer.sv
// Packs 2-bit symbols MSB-first into bytes; emits a one-cycle byte_valid pulse
// the cycle after the fourth symbol of each byte.
module sym_packer
    import pdf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [SYM_W-1:0]  sym_in,
    input  logic              sym_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid
);

    localparam int ACC_W = BYTE_W - SYM_W;

    logic [1:0]       sym_cnt;
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt    <= '0;
            acc        <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else if (clear) begin
            // byte_out deliberately holds; only the partial byte is dropped
            sym_cnt    <= '0;
            acc        <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (sym_valid) begin
                sym_cnt <= sym_cnt + 2'd1;
                if (sym_cnt == 2'd3) begin
                    byte_out   <= {acc, sym_in};
                    byte_valid <= 1'b1;
                end else begin
                    acc <= {acc[ACC_W-SYM_W-1:0], sym_in};
                end
            end
        end
    end

endmodule

// File: rtl/pdf_magic_detector.sv
// Scans the packed byte stream for "%PDF" within a bounded window and reports a
// sticky found/fail verdict with the byte offset of the match.
//
// state    | meaning
// ST_S0    | nothing matched
// ST_S1    | '%' seen
// ST_S2    | "%P" seen
// ST_S3    | "%PD" seen
// ST_FOUND | magic detected (terminal until start/reset)
// ST_FAIL  | window exhausted without a match (terminal until start/reset)
module pdf_magic_detector
    import pdf_pkg::*;
#(
    parameter int MAX_BYTES = 16,
    parameter int POS_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SYM_W-1:0]  sym_in,
    input  logic              sym_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              found,
    output logic              fail,
    output logic [POS_W-1:0]  match_pos,
    output logic              busy
);

    localparam logic [POS_W-1:0] MAX_CNT = POS_W'(MAX_BYTES);

    match_state_t     state;
    match_state_t     step_state;
    logic [POS_W-1:0] byte_cnt;
    logic [POS_W-1:0] cnt_inc;

    sym_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid)
    );

    always_comb begin
        step_state = match_step(state, byte_out);
        cnt_inc    = (byte_cnt == '1) ? byte_cnt : byte_cnt + POS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_S0;
            byte_cnt  <= '0;
            found     <= 1'b0;
            fail      <= 1'b0;
            match_pos <= '0;
            busy      <= 1'b1;
        end else if (start) begin
            state     <= ST_S0;
            byte_cnt  <= '0;
            found     <= 1'b0;
            fail      <= 1'b0;
            match_pos <= '0;
            busy      <= 1'b1;
        end else if (byte_valid && busy) begin
            byte_cnt <= cnt_inc;
            // a match completing on the last window byte beats the fail
            if (step_state == ST_FOUND) begin
                state     <= ST_FOUND;
                found     <= 1'b1;
                busy      <= 1'b0;
                match_pos <= byte_cnt - POS_W'(3);
            end else if (cnt_inc == MAX_CNT) begin
                state <= ST_FAIL;
                fail  <= 1'b1;
                busy  <= 1'b0;
            end else begin
                state <= step_state;
            end
        end
    end

endmodule

// File: tb/tb_pdf_magic_detector.sv
// Directed self-checking bench for pdf_magic_detector: packing, matching,
// window fail, match/fail tie, mismatch fallback, reset and start handling.
module tb_pdf_magic_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       found;
    logic       fail;
    logic [4:0] match_pos;
    logic       busy;

    int checks = 0;
    int errors = 0;

    pdf_magic_detector #(.MAX_BYTES(16), .POS_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .found      (found),
        .fail       (fail),
        .match_pos  (match_pos),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends one byte MSB-first; gap idle cycles follow every symbol.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < 4; i++) begin
            sym(b[7-2*i -: 2]);
            if (i == 0) chk("byte_valid_low", 32'(byte_valid), 32'd0);
            if (i == 3) begin
                chk("byte_valid_pulse", 32'(byte_valid), 32'd1);
                chk("byte_out", 32'(byte_out), 32'(b));
            end
            repeat (gap) tick();
        end
    endtask

    task automatic send_magic(input int gap);
        send_byte(8'h25, gap);
        send_byte(8'h50, gap);
        send_byte(8'h44, gap);
        send_byte(8'h46, gap);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        sym_in    = 2'd0;
        sym_valid = 1'b0;
        #12;
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_match_pos", 32'(match_pos), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back magic at offset 0
        pulse_start();
        send_magic(0);
        chk("t1_found_not_yet", 32'(found), 32'd0);
        tick();
        chk("t1_found", 32'(found), 32'd1);
        chk("t1_match_pos", 32'(match_pos), 32'd0);
        chk("t1_fail", 32'(fail), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_byte_valid_low", 32'(byte_valid), 32'd0);

        // start clears the verdict but holds byte_out
        pulse_start();
        chk("start_found", 32'(found), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_byte_out_hold", 32'(byte_out), 32'h46);
        chk("start_byte_valid", 32'(byte_valid), 32'd0);

        // 2: repeated '%' with stalls between symbols
        send_byte(8'h00, 1);
        send_byte(8'h25, 1);
        send_byte(8'h25, 1);
        send_byte(8'h50, 1);
        send_byte(8'h44, 1);
        chk("t2_found_not_yet", 32'(found), 32'd0);
        send_byte(8'h46, 1);
        chk("t2_found", 32'(found), 32'd1);
        chk("t2_match_pos", 32'(match_pos), 32'd2);
        chk("t2_busy", 32'(busy), 32'd0);

        // 3: window exhausted
        pulse_start();
        for (int k = 0; k < 16; k++) send_byte(8'h41, 0);
        chk("t3_fail_not_yet", 32'(fail), 32'd0);
        chk("t3_busy_not_yet", 32'(busy), 32'd1);
        tick();
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_found", 32'(found), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        send_magic(0);
        tick();
        chk("t3_fail_hold", 32'(fail), 32'd1);
        chk("t3_found_terminal", 32'(found), 32'd0);

        // 4: partial byte discarded by start, magic completes on byte 16
        sym(2'd1);
        sym(2'd1);
        pulse_start();
        for (int k = 0; k < 12; k++) send_byte(8'h41, 0);
        send_magic(0);
        tick();
        chk("t4_found", 32'(found), 32'd1);
        chk("t4_match_pos", 32'(match_pos), 32'd12);
        chk("t4_fail", 32'(fail), 32'd0);
        send_byte(8'h41, 0);
        tick();
        chk("t4_match_pos_hold", 32'(match_pos), 32'd12);
        chk("t4_fail_hold", 32'(fail), 32'd0);

        // 5: "%PDG" falls back, then a real match
        pulse_start();
        send_byte(8'h25, 0);
        send_byte(8'h50, 0);
        send_byte(8'h44, 0);
        send_byte(8'h47, 0);
        tick();
        chk("t5_found_after_g", 32'(found), 32'd0);
        chk("t5_busy_after_g", 32'(busy), 32'd1);
        send_magic(0);
        tick();
        chk("t5_found", 32'(found), 32'd1);
        chk("t5_match_pos", 32'(match_pos), 32'd4);

        // 6: async reset mid-byte, then start with a coincident symbol
        pulse_start();
        sym(2'd0);
        sym(2'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_byte_out", 32'(byte_out), 32'd0);
        chk("t6_rst_found", 32'(found), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd1);
        chk("t6_rst_match_pos", 32'(match_pos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_busy_after_rst", 32'(busy), 32'd1);
        start     = 1'b1;
        sym_in    = 2'd3;
        sym_valid = 1'b1;
        tick();
        start     = 1'b0;
        sym_valid = 1'b0;
        send_magic(0);
        tick();
        chk("t6_found", 32'(found), 32'd1);
        chk("t6_match_pos", 32'(match_pos), 32'd0);
        chk("t6_fail", 32'(fail), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
